mips_cpu_exec_core: RTL and testbench

//  Execution datapath of the multicycle MIPS32 CPU: 32x32 register file, combinational ALU and

---
 rtl/mips_cpu_exec_core_pkg.sv | 28 ++
 rtl/mips_cpu_exec_core_if.sv | 33 +++
 rtl/mips_cpu_exec_core_regfile.sv | 38 +++
 rtl/mips_cpu_exec_core.sv | 72 +++++++
 tb/tb_mips_cpu_exec_core.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_exec_core_pkg.sv
// mips_cpu_pkg: shared types and constants for the MIPS32 execution core.
//   aluop_t   ALU operation codes driven on the op bus
//   REG_*     architectural register indices used by the datapath
// Optional feature macro: MIPS_ALU_SLTU_EN enables op 13 (SLTU) in the ALU.
package mips_cpu_pkg;

   typedef enum logic [4:0] {
      ALU_AND  = 5'd0,
      ALU_OR   = 5'd1,
      ALU_ADD  = 5'd2,
      ALU_SUB  = 5'd3,
      ALU_SLT  = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SLL  = 5'd6,
      ALU_SRL  = 5'd7,
      ALU_SRA  = 5'd8,
      ALU_SLLV = 5'd9,
      ALU_SRLV = 5'd10,
      ALU_SRAV = 5'd11,
      ALU_LUI  = 5'd12,
      ALU_SLTU = 5'd13
   } aluop_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_V0   = 5'd2;
   localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_cpu_exec_core_if.sv
// mips_cpu_exec_core_if: datapath bus between the multicycle control FSM
// (master) and the execution core (slave).
//   register file : write, wrAddr, wrData, rdAddrA/B -> rdDataA/B, register_v0
//   ALU           : op, a, b, sa -> result, zero
//   multiplier    : a, b, sign -> out ({HI,LO})
interface mips_cpu_exec_core_if;
   logic        write;
   logic [4:0]  wrAddr;
   logic [31:0] wrData;
   logic [4:0]  rdAddrA;
   logic [31:0] rdDataA;
   logic [4:0]  rdAddrB;
   logic [31:0] rdDataB;
   logic [31:0] register_v0;
   logic [4:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  sa;
   logic [31:0] result;
   logic        zero;
   logic        sign;
   logic [63:0] out;

   modport master (
      output write, wrAddr, wrData, rdAddrA, rdAddrB, op, a, b, sa, sign,
      input  rdDataA, rdDataB, register_v0, result, zero, out
   );

   modport slave (
      input  write, wrAddr, wrData, rdAddrA, rdAddrB, op, a, b, sa, sign,
      output rdDataA, rdDataB, register_v0, result, zero, out
   );
endinterface

// File: rtl/mips_cpu_exec_core_regfile.sv
// mips_cpu_regfile: 32x32 register file, one write port, two combinational
// read ports and a live view of $v0.
//   clk, reset        clock, async active-high clear of all registers
//   write/wrAddr/wrData  synchronous write; writes to $0 are dropped
//   rdAddrA/B -> rdDataA/B  zero-latency reads (old value during a write)
//   register_v0       contents of register 2
import mips_cpu_pkg::*;

module mips_cpu_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic        write,
   input  logic [4:0]  wrAddr,
   input  logic [31:0] wrData,
   input  logic [4:0]  rdAddrA,
   output logic [31:0] rdDataA,
   input  logic [4:0]  rdAddrB,
   output logic [31:0] rdDataB,
   output logic [31:0] register_v0
);

   logic [31:0] regs [32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (write && wrAddr != REG_ZERO) begin
         regs[wrAddr] <= wrData;
      end
   end

   // $0 is never written, but forcing zero keeps the read path independent
   // of whatever synthesis does with the unused storage row.
   assign rdDataA     = (rdAddrA == REG_ZERO) ? '0 : regs[rdAddrA];
   assign rdDataB     = (rdAddrB == REG_ZERO) ? '0 : regs[rdAddrB];
   assign register_v0 = regs[REG_V0];

endmodule

// File: rtl/mips_cpu_exec_core.sv
// mips_cpu_exec_core: execution datapath of the multicycle MIPS32 CPU.
//   clk, reset  clock and async active-high reset (clears the register file)
//   bus         slave side of mips_cpu_exec_core_if: register file ports,
//               ALU (op/a/b/sa -> result/zero), multiplier (a/b/sign -> out)
// Build option: define MIPS_ALU_SLTU_EN to add SLTU as op 13; otherwise op 13
// behaves like any undefined op and returns 0.
import mips_cpu_pkg::*;

module mips_cpu_exec_core (
   input  logic                 clk,
   input  logic                 reset,
   mips_cpu_exec_core_if.slave  bus
);

   mips_cpu_regfile u_regfile (
      .clk         (clk),
      .reset       (reset),
      .write       (bus.write),
      .wrAddr      (bus.wrAddr),
      .wrData      (bus.wrData),
      .rdAddrA     (bus.rdAddrA),
      .rdDataA     (bus.rdDataA),
      .rdAddrB     (bus.rdAddrB),
      .rdDataB     (bus.rdDataB),
      .register_v0 (bus.register_v0)
   );

   logic [31:0] alu_res;
   logic [4:0]  var_sa;

   // Variable shifts only honour the low five bits of rs.
   assign var_sa = bus.a[4:0];

   always_comb begin
      alu_res = '0;
      case (bus.op)
         ALU_AND:  alu_res = bus.a & bus.b;
         ALU_OR:   alu_res = bus.a | bus.b;
         ALU_ADD:  alu_res = bus.a + bus.b;
         ALU_SUB:  alu_res = bus.a - bus.b;
         ALU_SLT:  alu_res = {31'd0, $signed(bus.a) < $signed(bus.b)};
         ALU_XOR:  alu_res = bus.a ^ bus.b;
         ALU_SLL:  alu_res = bus.b << bus.sa;
         ALU_SRL:  alu_res = bus.b >> bus.sa;
         ALU_SRA:  alu_res = $signed(bus.b) >>> bus.sa;
         ALU_SLLV: alu_res = bus.b << var_sa;
         ALU_SRLV: alu_res = bus.b >> var_sa;
         ALU_SRAV: alu_res = $signed(bus.b) >>> var_sa;
         ALU_LUI:  alu_res = {bus.b[15:0], 16'h0000};
`ifdef MIPS_ALU_SLTU_EN
         ALU_SLTU: alu_res = {31'd0, bus.a < bus.b};
`endif
         default:  alu_res = '0;
      endcase
   end

   assign bus.result = alu_res;
   assign bus.zero   = (alu_res == '0);

   // Extending both operands to 64 bits according to sign and keeping the low
   // 64 bits of the product gives the correct signed or unsigned result with
   // a single multiplier.
   logic [63:0] mul_a;
   logic [63:0] mul_b;

   always_comb begin
      mul_a   = {(bus.sign ? {32{bus.a[31]}} : 32'd0), bus.a};
      mul_b   = {(bus.sign ? {32{bus.b[31]}} : 32'd0), bus.b};
      bus.out = mul_a * mul_b;
   end

endmodule

// File: tb/tb_mips_cpu_exec_core.sv
module tb_mips_cpu_exec_core;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] model [32];

   always #5 clk = ~clk;

   mips_cpu_exec_core_if bus ();

   mips_cpu_exec_core dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic longint pow2(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 2;
      return p;
   endfunction

   // Reference ALU written as plain arithmetic (shifts as multiply/divide).
   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                           input logic [31:0] b, input int sa);
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      longint r  = 0;
      int     vs = int'({27'd0, a[4:0]});
      case (op)
         0:  r = ua & ub;
         1:  r = ua | ub;
         2:  r = ua + ub;
         3:  r = ua - ub;
         4:  r = (int'(a) < int'(b)) ? 1 : 0;
         5:  r = ua ^ ub;
         6:  r = ub * pow2(sa);
         7:  r = ub / pow2(sa);
         8:  r = b[31] ? ~((ub ^ 64'hFFFF_FFFF) / pow2(sa)) : ub / pow2(sa);
         9:  r = ub * pow2(vs);
         10: r = ub / pow2(vs);
         11: r = b[31] ? ~((ub ^ 64'hFFFF_FFFF) / pow2(vs)) : ub / pow2(vs);
         12: r = (ub % 65536) * 65536;
`ifdef MIPS_ALU_SLTU_EN
         13: r = (ua < ub) ? 1 : 0;
`endif
         default: r = 0;
      endcase
      return r[31:0];
   endfunction

   function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ua = {32'd0, a};
      logic [63:0] ub = {32'd0, b};
      longint sp;
      if (sgn) begin
         sp = longint'(int'(a)) * longint'(int'(b));
         return sp;
      end
      return ua * ub;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic alu_directed(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sa, input logic [31:0] exp_res);
      @(negedge clk);
      bus.op = op; bus.a = a; bus.b = b; bus.sa = sa;
      #1;
      check(tag, {32'd0, bus.result}, {32'd0, exp_res});
      check({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, exp_res == 32'd0});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      reset = 1'b1;
      bus.write = 0; bus.wrAddr = 0; bus.wrData = 0;
      bus.rdAddrA = 5; bus.rdAddrB = 2;
      bus.op = 0; bus.a = 0; bus.b = 0; bus.sa = 0; bus.sign = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdA", {32'd0, bus.rdDataA}, 64'd0);
      check("reset_rdB", {32'd0, bus.rdDataB}, 64'd0);
      check("reset_v0", {32'd0, bus.register_v0}, 64'd0);

      @(negedge clk);
      reset = 1'b0;
      bus.write = 1; bus.wrAddr = 0; bus.wrData = 32'hDEADBEEF; bus.rdAddrA = 0;
      @(posedge clk); #1;
      check("r0_ignored", {32'd0, bus.rdDataA}, 64'd0);

      @(negedge clk);
      bus.wrAddr = 2; bus.rdAddrB = 2;
      #1;
      check("v0_old_before_edge", {32'd0, bus.register_v0}, 64'd0);
      check("rdB_old_before_edge", {32'd0, bus.rdDataB}, 64'd0);
      @(posedge clk); #1;
      model[2] = 32'hDEADBEEF;
      check("v0_after_write", {32'd0, bus.register_v0}, 64'h0000_0000_DEAD_BEEF);

      // Random mixed traffic: register writes/reads plus ALU and multiplier.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         bus.write   = ($urandom_range(0, 3) != 0);
         bus.wrAddr  = 5'($urandom_range(0, 31));
         bus.wrData  = $urandom;
         bus.rdAddrA = ($urandom_range(0, 3) == 0) ? bus.wrAddr : 5'($urandom_range(0, 31));
         bus.rdAddrB = 5'($urandom_range(0, 31));
         bus.op      = 5'($urandom_range(0, 15));
         bus.a       = pick_operand();
         bus.b       = pick_operand();
         bus.sa      = 5'($urandom_range(0, 31));
         bus.sign    = 1'($urandom_range(0, 1));
         #1;
         check("rand_rdA", {32'd0, bus.rdDataA}, {32'd0, model[bus.rdAddrA]});
         check("rand_rdB", {32'd0, bus.rdDataB}, {32'd0, model[bus.rdAddrB]});
         check("rand_v0", {32'd0, bus.register_v0}, {32'd0, model[2]});
         check("rand_alu", {32'd0, bus.result},
               {32'd0, ref_alu(int'(bus.op), bus.a, bus.b, int'(bus.sa))});
         check("rand_zero", {63'd0, bus.zero},
               {63'd0, ref_alu(int'(bus.op), bus.a, bus.b, int'(bus.sa)) == 32'd0});
         check("rand_mul", bus.out, ref_mul(bus.sign, bus.a, bus.b));
         @(posedge clk);
         if (bus.write && bus.wrAddr != 0) model[bus.wrAddr] = bus.wrData;
      end

      // Ensure $v0 is nonzero, then reset mid-run and check before any edge.
      @(negedge clk);
      bus.write = 1; bus.wrAddr = 2; bus.wrData = 32'h1234_5678;
      @(posedge clk); #1;
      check("v0_pre_reset", {32'd0, bus.register_v0}, 64'h0000_0000_1234_5678);
      @(negedge clk);
      bus.write = 0; bus.rdAddrA = 2; bus.rdAddrB = 31;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      check("midreset_rdA", {32'd0, bus.rdDataA}, 64'd0);
      check("midreset_rdB", {32'd0, bus.rdDataB}, 64'd0);
      check("midreset_v0", {32'd0, bus.register_v0}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      alu_directed("add_wrap", 5'd2, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0);
      alu_directed("sub", 5'd3, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE);
      alu_directed("slt", 5'd4, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1);
      alu_directed("sra", 5'd8, 32'd0, 32'h80000000, 5'd4, 32'hF8000000);
      alu_directed("srlv", 5'd10, 32'd36, 32'h80000000, 5'd0, 32'h08000000);
      alu_directed("lui", 5'd12, 32'd0, 32'hFFFF1234, 5'd0, 32'h12340000);
`ifdef MIPS_ALU_SLTU_EN
      alu_directed("sltu", 5'd13, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd1);
`else
      alu_directed("op13_off", 5'd13, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0);
`endif
      alu_directed("op_undef", 5'd20, 32'd3, 32'd3, 5'd0, 32'd0);

      @(negedge clk);
      bus.a = 32'hFFFFFFFF; bus.b = 32'd2; bus.sign = 1;
      #1;
      check("mul_signed", bus.out, 64'hFFFFFFFFFFFFFFFE);
      bus.sign = 0;
      #1;
      check("mul_unsigned", bus.out, 64'h00000001FFFFFFFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
